ir_code_receiver: RTL
=====================

IR_CODE_RECEIVER -- requirements
Module: ir_code_receiver

Interface
REQ-001 Parameter CODE_W, default 3: number of data bits per frame.
REQ-002 Parameter BIT_TICKS, default 10: clk cycles per data bit.
REQ-003 Parameter START_TICKS, default 5: clk cycles from start-edge detection to start-bit re-check.
REQ-004 Parameter VALID_MASK, width 2**CODE_W, default 8'b0101_1110: bit i set means code i is accepted (default accepts codes 1, 2, 3, 4 and 6).
REQ-005 Parameter RDY_LEN, default 4: rdy pulse length in clk cycles, minimum 1.
REQ-006 clk  input  1: single clock; all state updates on rising edge.
REQ-007 rst  input  1: asynchronous, active-low reset.
REQ-008 irda  input  1: asynchronous IR line, idle high, active low.
REQ-009 code  output  CODE_W: last accepted code, MSB received first.
REQ-010 rdy  output  1: high for exactly RDY_LEN cycles per accepted frame.
REQ-011 err  output  1: one-cycle pulse per rejected frame.
REQ-012 frame_cnt  output  8: count of start bits that passed the re-check, wrapping 255->0.

Function
REQ-013 irda SHALL pass through a 2-flop synchroniser; all logic SHALL use the synchronised value.
REQ-014 A start edge SHALL be a high-to-low transition of the synchronised line.
REQ-015 FSM states SHALL be IDLE, START, DATA, CHECK, HOLD and WAIT_HI.
REQ-016 IDLE: on a start edge, clear the tick counter and go to START; all other inputs are ignored.
REQ-017 START: on tick START_TICKS-1, a low line SHALL increment frame_cnt and go to DATA; a high line is a glitch, goes to IDLE, and raises neither err nor a frame_cnt change.
REQ-018 DATA: sample the line every BIT_TICKS cycles, first sample BIT_TICKS cycles after the start re-check; shift MSB first into an internal register; after CODE_W samples go to CHECK.
REQ-019 CHECK (one cycle): if VALID_MASK[shift register] is 1, load code, go to HOLD and assert rdy from the next cycle; otherwise pulse err for one cycle, leave code unchanged and go to WAIT_HI.
REQ-020 HOLD: keep rdy high for RDY_LEN cycles, then deassert it and go to WAIT_HI.
REQ-021 code SHALL stay stable while rdy is high and change only on entry to HOLD.
REQ-022 WAIT_HI: return to IDLE only once the synchronised line is high, so a held-low line cannot retrigger.
REQ-023 Start edges in START, DATA, CHECK, HOLD and WAIT_HI SHALL be ignored; there is no frame queueing.
REQ-024 Tick counter width SHALL be clog2(max(BIT_TICKS, START_TICKS)+1).
REQ-025 rdy and err SHALL never be high in the same cycle.

Reset
REQ-026 Asserting rst (low) SHALL immediately force the FSM to IDLE, the synchroniser to 1, code to 0, rdy to 0, err to 0, frame_cnt to 0, and the counters and shift register to 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release the line must show a fresh high-to-low edge before reception restarts.

Structure
REQ-028 The shared package ir_pkg SHALL hold the state enum typedef and the default VALID_MASK constant.
REQ-029 Synchronisation and edge detection SHALL live in the sub-module ir_sync (ports clk, rst, din, dout, fall).
REQ-030 All outputs SHALL be registered.
REQ-031 Target implementation size is 120-400 lines.

Verification (defaults unless stated)
REQ-032 Send frame 0-1-1 (code 3) with 10-cycle bits -> code=3'b011, rdy high 4 cycles, frame_cnt=1, err stays 0.
REQ-033 Send code 5 (not in mask) -> err pulses for 1 cycle, code keeps its previous value, rdy stays 0, frame_cnt increments.
REQ-034 Hold irda low for 3 cycles, then high -> START rejects the glitch, no err, frame_cnt unchanged, FSM back in IDLE.
REQ-035 Assert rst during the second data bit of a frame -> all outputs read 0 at once; a following valid code 6 frame gives code=6 and frame_cnt=1.
REQ-036 Set CODE_W=4, VALID_MASK bit 9 only, BIT_TICKS=16, and send code 9 -> code=4'b1001, rdy high; a second start edge inside HOLD is ignored.
REQ-037 Send 256 valid frames -> frame_cnt wraps to 0, and every rdy pulse is exactly RDY_LEN cycles long.

Source files
------------

// File: rtl/ir_pkg.sv
// ir_pkg: shared FSM state type, default code acceptance mask and a small helper.
// Rev 1.0
`default_nettype none

package ir_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    CHECK   = 3'd3,
    HOLD    = 3'd4,
    WAIT_HI = 3'd5
  } ir_state_e;

  // Accepts codes 1, 2, 3, 4 and 6 for the default 3-bit frame.
  localparam logic [7:0] IR_VALID_MASK_DEF = 8'b0101_1110;

  function automatic int ir_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ir_code_receiver_if.sv
// ir_code_receiver_if: IR line input and decoded-code outputs of the receiver.
// Rev 1.0
`default_nettype none

interface ir_code_receiver_if #(
  parameter int CODE_W = 3
);
  logic              irda;
  logic [CODE_W-1:0] code;
  logic              rdy;
  logic              err;
  logic [7:0]        frame_cnt;

  modport master (input irda, output code, rdy, err, frame_cnt);
  modport slave  (output irda, input code, rdy, err, frame_cnt);
endinterface

`default_nettype wire

// File: rtl/ir_sync.sv
// ir_sync: two-flop synchroniser for the IR line plus falling-edge detect.
// Rev 1.0
`default_nettype none

module ir_sync (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic din,
  output logic      dout,
  output logic      fall
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // Resetting to 1 (idle level) keeps a quiet line from looking like an edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign dout = s2_q;
  assign fall = prev_q & ~s2_q;

endmodule

`default_nettype wire

// File: rtl/ir_code_receiver.sv
// ir_code_receiver: receives start bit + CODE_W data bits (MSB first) from an IR line,
// publishes accepted codes with a fixed-length rdy pulse and flags rejected ones with err.
`default_nettype none

module ir_code_receiver
  import ir_pkg::*;
#(
  parameter int                    CODE_W      = 3,
  parameter int                    BIT_TICKS   = 10,
  parameter int                    START_TICKS = 5,
  parameter logic [2**CODE_W-1:0]  VALID_MASK  = IR_VALID_MASK_DEF,
  parameter int                    RDY_LEN     = 4
) (
  input wire logic               clk,
  input wire logic               rst,
  ir_code_receiver_if.master     bus
);

  localparam int TW = $clog2(ir_max(BIT_TICKS, START_TICKS) + 1);
  localparam int BW = $clog2(CODE_W + 1);
  localparam int HW = $clog2(RDY_LEN + 1);

  localparam logic [TW-1:0] START_LAST = TW'(START_TICKS - 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_TICKS - 1);
  localparam logic [BW-1:0] NBIT_LAST  = BW'(CODE_W - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RDY_LEN - 1);

  logic line;
  logic fall;

  ir_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.irda),
    .dout (line),
    .fall (fall)
  );

  ir_state_e         state_q;
  logic [TW-1:0]     tick_q;
  logic [BW-1:0]     bit_q;
  logic [HW-1:0]     hold_q;
  logic [CODE_W-1:0] shift_q;
  logic [CODE_W-1:0] code_q;
  logic              rdy_q;
  logic              err_q;
  logic [7:0]        frame_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      hold_q      <= '0;
      shift_q     <= '0;
      code_q      <= '0;
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            tick_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (tick_q == START_LAST) begin
            tick_q <= '0;
            bit_q  <= '0;
            // A line already back high here was only a glitch.
            if (!line) begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
              state_q     <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == BIT_LAST) begin
            tick_q  <= '0;
            shift_q <= {shift_q[CODE_W-2:0], line};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == NBIT_LAST) begin
              state_q <= CHECK;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        CHECK: begin
          if (VALID_MASK[shift_q]) begin
            code_q  <= shift_q;
            rdy_q   <= 1'b1;
            hold_q  <= '0;
            state_q <= HOLD;
          end else begin
            err_q   <= 1'b1;
            state_q <= WAIT_HI;
          end
        end
        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            rdy_q   <= 1'b0;
            state_q <= WAIT_HI;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        WAIT_HI: begin
          if (line) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.code      = code_q;
  assign bus.rdy       = rdy_q;
  assign bus.err       = err_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire
